insight_mstatus_tracker: RTL and testbench
==========================================

INSIGHT_MSTATUS_TRACKER -- requirements
Module: insight_mstatus_tracker

Interface
REQ-001 SHALL: parameter NUM_HARTS, default 2, number of hart channels observed (1..8).
REQ-002 SHALL: parameter STATUS_W, default 32, width of each hart's mstatus sample (32 or 64).
REQ-003 SHALL: parameter DEPTH, default 4, record FIFO entries (power of 2, >=2).
REQ-004 SHALL: parameter TRACK_MASK, default all ones (STATUS_W bits), status bits that participate in change detection and output.
REQ-005 SHALL: clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL: reset  in  1  synchronous, active-high reset.
REQ-007 SHALL: in_valid  in  NUM_HARTS  per-hart sample-valid strobe.
REQ-008 SHALL: in_status  in  NUM_HARTS*STATUS_W  hart h sample at [h*STATUS_W +: STATUS_W].
REQ-009 SHALL: in_prv  in  NUM_HARTS*2  hart h privilege (dprv) at [2h +: 2].
REQ-010 SHALL: snap_req  in  1  one-cycle pulse requesting a forced record from every hart.
REQ-011 SHALL: out_valid  out  1  FIFO head record valid.
REQ-012 SHALL: out_ready  in  1  consumer accepts head when out_valid high.
REQ-013 SHALL: out_hart  out  max(1,clog2(NUM_HARTS))  hart index of head record.
REQ-014 SHALL: out_status  out  STATUS_W  masked status of head record (bits outside TRACK_MASK = 0).
REQ-015 SHALL: out_prv  out  2  privilege of head record.
REQ-016 SHALL: out_coalesced  out  1  head record replaced at least one older unsent record.
REQ-017 SHALL: drop_count  out  16  saturating count of coalesced (lost) records.

Function
REQ-018 SHALL: per hart hold last-captured {masked status, prv}, an armed flag, a snap flag and a one-entry pending record {status, prv, coalesced}.
REQ-019 SHALL: capture event for hart h = in_valid[h] AND (armed[h] OR masked status != last OR prv != last prv OR snap[h]).
REQ-020 SHALL: on capture, update last value, clear armed[h] and snap[h], and load pending[h] in the same edge.
REQ-021 SHALL: capture into an occupied pending[h] not granted that cycle overwrites it with coalesced=1 and increments drop_count, saturating at 0xFFFF.
REQ-022 SHALL: capture in the same cycle hart h is granted push the old pending record to FIFO and load the new one with coalesced=0.
REQ-023 SHALL: snap_req set snap[h] for all harts; a snap_req coincident with a capture leaves snap[h] set.
REQ-024 SHALL: at most one pending record pushed per cycle, chosen round-robin starting at rr_ptr; rr_ptr moves to granted index+1 (mod NUM_HARTS) only on a push.
REQ-025 SHALL: push allowed when FIFO count < DEPTH, or count == DEPTH and a pop occurs the same cycle.
REQ-026 SHALL: out_valid = (count != 0); pop when out_valid AND out_ready; head fields held stable while out_valid AND NOT out_ready.
REQ-027 SHALL: simultaneous push and pop keep count unchanged; push into empty FIFO is visible next cycle (no combinational bypass).
REQ-028 SHALL: minimum latency capture sample at cycle N -> pending at N+1 -> out_valid at N+2.
REQ-029 SHALL: pointers wrap modulo DEPTH; count ranges 0..DEPTH.

Reset
REQ-030 SHALL: reset clears FIFO, pending, snap flags, last values, rr_ptr and drop_count, and sets armed for every hart.
REQ-031 SHALL: during and after reset out_valid=0, out_hart=0, out_status=0, out_prv=0, out_coalesced=0, drop_count=0.
REQ-032 SHALL: reset mid-operation discard all queued and pending records with no partial output.

Verification
REQ-033 SHALL: after reset, hart0 in_valid with status 0x0000_1888, prv 3, out_ready=1 -> two cycles later out_valid=1, hart 0, status 0x0000_1888, prv 3, coalesced 0.
REQ-034 SHALL: repeat identical sample on hart0 for 10 cycles -> no further records; change bit 3 -> exactly one record.
REQ-035 SHALL: out_ready=0, DEPTH=4, hart0 changes value on 7 consecutive cycles -> 4 records queued, pending coalesced, drop_count=2; release -> 5th record has coalesced=1.
REQ-036 SHALL: both harts capture same cycle with rr_ptr=0 -> hart0 record then hart1 record on consecutive cycles; next tie grants hart1... only after rr_ptr advance confirmed.
REQ-037 SHALL: snap_req with unchanged samples on all harts -> one record per hart; reset asserted with FIFO non-empty -> out_valid=0 next cycle and drop_count=0.

Source files
------------

// File: rtl/insight_mstatus_tracker_if.sv
// ============================================================================
// Module   : insight_mstatus_tracker_if
// Brief    : Hart sample inputs and record-stream outputs of the mstatus tracker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface insight_mstatus_tracker_if #(
    parameter int NUM_HARTS = 2,
    parameter int STATUS_W  = 32
);
    localparam int C_HART_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

    logic [NUM_HARTS-1:0]          in_valid;
    logic [NUM_HARTS*STATUS_W-1:0] in_status;
    logic [NUM_HARTS*2-1:0]        in_prv;
    logic                          snap_req;
    logic                          out_valid;
    logic                          out_ready;
    logic [C_HART_W-1:0]           out_hart;
    logic [STATUS_W-1:0]           out_status;
    logic [1:0]                    out_prv;
    logic                          out_coalesced;
    logic [15:0]                   drop_count;

    modport master (
        output in_valid, in_status, in_prv, snap_req, out_ready,
        input  out_valid, out_hart, out_status, out_prv, out_coalesced, drop_count
    );

    modport slave (
        input  in_valid, in_status, in_prv, snap_req, out_ready,
        output out_valid, out_hart, out_status, out_prv, out_coalesced, drop_count
    );
endinterface

`default_nettype wire

// File: rtl/insight_mstatus_tracker.sv
// ============================================================================
// Module   : insight_mstatus_tracker
// Brief    : Per-hart mstatus change detector feeding a round-robin record FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module insight_mstatus_tracker #(
    parameter int                  NUM_HARTS  = 2,
    parameter int                  STATUS_W   = 32,
    parameter int                  DEPTH      = 4,
    parameter logic [STATUS_W-1:0] TRACK_MASK = {STATUS_W{1'b1}}
) (
    input  wire logic                 clock,
    input  wire logic                 reset,
    insight_mstatus_tracker_if.slave  bus
);
    localparam int C_HART_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
    localparam int C_PTR_W  = $clog2(DEPTH);
    localparam int C_CNT_W  = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(DEPTH);

    logic [STATUS_W-1:0] r_last_status [NUM_HARTS];
    logic [1:0]          r_last_prv    [NUM_HARTS];
    logic [STATUS_W-1:0] r_pend_status [NUM_HARTS];
    logic [1:0]          r_pend_prv    [NUM_HARTS];
    logic [NUM_HARTS-1:0] r_armed, r_snap, r_pend_v, r_pend_coal;
    logic [C_HART_W-1:0] r_rr;

    logic [C_HART_W-1:0] r_fifo_hart   [DEPTH];
    logic [STATUS_W-1:0] r_fifo_status [DEPTH];
    logic [1:0]          r_fifo_prv    [DEPTH];
    logic                r_fifo_coal   [DEPTH];
    logic [C_PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [C_CNT_W-1:0]  r_count;
    logic [15:0]         r_drop;

    logic [STATUS_W-1:0] w_masked [NUM_HARTS];
    logic [1:0]          w_prv    [NUM_HARTS];
    logic [NUM_HARTS-1:0] w_cap, w_gnt_hit, w_coal;
    logic                w_gnt_valid;
    logic [C_HART_W-1:0] w_gnt_idx, w_rr_next, w_idx;
    logic                w_pop, w_push_ok, w_out_valid;
    logic [4:0]          w_ncoal;
    logic [16:0]         w_drop_sum;
    logic [15:0]         w_drop_next;

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        assign w_masked[h]  = bus.in_status[h*STATUS_W +: STATUS_W] & TRACK_MASK;
        assign w_prv[h]     = bus.in_prv[2*h +: 2];
        assign w_cap[h]     = bus.in_valid[h] & (r_armed[h] | r_snap[h] |
                              (w_masked[h] != r_last_status[h]) | (w_prv[h] != r_last_prv[h]));
        assign w_gnt_hit[h] = w_gnt_valid & (w_gnt_idx == C_HART_W'(h));
        // A capture landing on a pending record that is not leaving this cycle loses it.
        assign w_coal[h]    = w_cap[h] & r_pend_v[h] & ~w_gnt_hit[h];
    end

    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid & bus.out_ready;
    assign w_push_ok   = (r_count < C_DEPTH) | w_pop;

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_idx       = '0;
        w_rr_next   = r_rr;
        if (w_push_ok) begin
            for (int k = 0; k < NUM_HARTS; k++) begin
                w_idx = C_HART_W'((int'(r_rr) + k) % NUM_HARTS);
                if (!w_gnt_valid && r_pend_v[w_idx]) begin
                    w_gnt_valid = 1'b1;
                    w_gnt_idx   = w_idx;
                end
            end
        end
        if (w_gnt_valid) begin
            w_rr_next = ((int'(w_gnt_idx) + 1) == NUM_HARTS) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    always_comb begin
        w_ncoal = '0;
        for (int k = 0; k < NUM_HARTS; k++) begin
            w_ncoal = w_ncoal + 5'(w_coal[k]);
        end
        w_drop_sum  = {1'b0, r_drop} + {12'b0, w_ncoal};
        w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_last_status[h] <= '0;
                r_last_prv[h]    <= '0;
                r_pend_status[h] <= '0;
                r_pend_prv[h]    <= '0;
            end
            r_armed     <= '1;
            r_snap      <= '0;
            r_pend_v    <= '0;
            r_pend_coal <= '0;
            r_rr        <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_drop      <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (w_cap[h]) begin
                    r_last_status[h] <= w_masked[h];
                    r_last_prv[h]    <= w_prv[h];
                    r_armed[h]       <= 1'b0;
                    r_pend_status[h] <= w_masked[h];
                    r_pend_prv[h]    <= w_prv[h];
                    r_pend_v[h]      <= 1'b1;
                    r_pend_coal[h]   <= w_coal[h];
                end else if (w_gnt_hit[h]) begin
                    r_pend_v[h] <= 1'b0;
                end
                r_snap[h] <= bus.snap_req | (r_snap[h] & ~w_cap[h]);
            end
            if (w_gnt_valid) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)       r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_gnt_valid && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_gnt_valid && w_pop) r_count <= r_count - 1'b1;
            r_rr   <= w_rr_next;
            r_drop <= w_drop_next;
        end
    end

    // Storage needs no reset: reads are qualified by r_count.
    always_ff @(posedge clock) begin
        if (w_gnt_valid) begin
            r_fifo_hart[r_wr_ptr]   <= w_gnt_idx;
            r_fifo_status[r_wr_ptr] <= r_pend_status[w_gnt_idx];
            r_fifo_prv[r_wr_ptr]    <= r_pend_prv[w_gnt_idx];
            r_fifo_coal[r_wr_ptr]   <= r_pend_coal[w_gnt_idx];
        end
    end

    assign bus.out_valid     = w_out_valid;
    assign bus.out_hart      = w_out_valid ? r_fifo_hart[r_rd_ptr]   : '0;
    assign bus.out_status    = w_out_valid ? r_fifo_status[r_rd_ptr] : '0;
    assign bus.out_prv       = w_out_valid ? r_fifo_prv[r_rd_ptr]    : '0;
    assign bus.out_coalesced = w_out_valid ? r_fifo_coal[r_rd_ptr]   : 1'b0;
    assign bus.drop_count    = r_drop;
endmodule

`default_nettype wire

// File: tb/tb_insight_mstatus_tracker.sv
// ============================================================================
// Module   : tb_insight_mstatus_tracker
// Brief    : Scoreboard bench for the mstatus tracker (2 harts, 32-bit, depth 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_insight_mstatus_tracker;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    insight_mstatus_tracker_if #(.NUM_HARTS(2), .STATUS_W(32)) bus ();

    insight_mstatus_tracker #(.NUM_HARTS(2), .STATUS_W(32), .DEPTH(4)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic        hart;
        logic [31:0] status;
        logic [1:0]  prv;
        logic        coal;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_exp;
    rec_t mon_got;
    int   vectors     = 0;
    int   miscompares = 0;
    int   rec_seen    = 0;

    function automatic rec_t mk(input logic h, input logic [31:0] s, input logic [1:0] p, input logic c);
        rec_t r;
        r.hart = h; r.status = s; r.prv = p; r.coal = c;
        return r;
    endfunction

    // Scoreboard: every accepted head record is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            rec_seen++;
            vectors++;
            mon_got = mk(bus.out_hart, bus.out_status, bus.out_prv, bus.out_coalesced);
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_record: got hart=%0d status=%h prv=%0d coal=%0d, required none",
                         mon_got.hart, mon_got.status, mon_got.prv, mon_got.coal);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    miscompares++;
                    $display("FAIL record: got hart=%0d status=%h prv=%0d coal=%0d, required hart=%0d status=%h prv=%0d coal=%0d",
                             mon_got.hart, mon_got.status, mon_got.prv, mon_got.coal,
                             mon_exp.hart, mon_exp.status, mon_exp.prv, mon_exp.coal);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hart(input int h, input logic [31:0] s, input logic [1:0] p, input logic v);
        bus.in_status[h*32 +: 32] = s;
        bus.in_prv[2*h +: 2]      = p;
        bus.in_valid[h]           = v;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (exp_q.size() != 0 || bus.out_valid) begin
            miscompares++;
            $display("FAIL %s_drain: %0d records still expected after %0d cycles, required 0", name, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = '0; bus.in_status = '0; bus.in_prv = '0;
        bus.snap_req = 1'b0; bus.out_ready = 1'b0;
        tick(); tick();
        @(negedge clk);
        vectors += 6;
        if (bus.out_valid !== 1'b0)      begin miscompares++; $display("FAIL reset_valid: got %b, required 0", bus.out_valid); end
        if (bus.out_hart !== 1'b0)       begin miscompares++; $display("FAIL reset_hart: got %0d, required 0", bus.out_hart); end
        if (bus.out_status !== 32'h0)    begin miscompares++; $display("FAIL reset_status: got %h, required 0", bus.out_status); end
        if (bus.out_prv !== 2'd0)        begin miscompares++; $display("FAIL reset_prv: got %0d, required 0", bus.out_prv); end
        if (bus.out_coalesced !== 1'b0)  begin miscompares++; $display("FAIL reset_coal: got %b, required 0", bus.out_coalesced); end
        if (bus.drop_count !== 16'd0)    begin miscompares++; $display("FAIL reset_drop: got %0d, required 0", bus.drop_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_first_record();
        bus.out_ready = 1'b1;
        set_hart(0, 32'h0000_1888, 2'd3, 1'b1);
        exp_q.push_back(mk(1'b0, 32'h0000_1888, 2'd3, 1'b0));
        tick();
        set_hart(0, 32'h0000_1888, 2'd3, 1'b0);
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL latency_n1: got out_valid=%b, required 0", bus.out_valid); end
        tick();
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL latency_n2: got out_valid=%b, required 1", bus.out_valid); end
        drain("first", 20);
    endtask

    task automatic test_no_change();
        int base = rec_seen;
        set_hart(0, 32'h0000_1888, 2'd3, 1'b1);
        repeat (10) tick();
        repeat (3) tick();
        vectors++;
        if (rec_seen != base) begin miscompares++; $display("FAIL repeat_sample: got %0d records, required 0", rec_seen - base); end
        set_hart(0, 32'h0000_1880, 2'd3, 1'b1);
        exp_q.push_back(mk(1'b0, 32'h0000_1880, 2'd3, 1'b0));
        repeat (6) tick();
        set_hart(0, 32'h0000_1880, 2'd3, 1'b0);
        drain("bit3", 20);
        vectors++;
        if (rec_seen != base + 1) begin miscompares++; $display("FAIL bit3_change: got %0d records, required 1", rec_seen - base); end
    endtask

    task automatic test_coalesce();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_hart(0, 32'h100 + i, 2'd3, 1'b1);
            tick();
        end
        set_hart(0, 32'h106, 2'd3, 1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, 32'h100 + i, 2'd3, 1'b0));
        exp_q.push_back(mk(1'b0, 32'h106, 2'd3, 1'b1));
        tick(); tick();
        @(negedge clk);
        vectors += 3;
        if (bus.drop_count !== 16'd2)     begin miscompares++; $display("FAIL coal_drop: got %0d, required 2", bus.drop_count); end
        if (bus.out_valid !== 1'b1)       begin miscompares++; $display("FAIL coal_valid: got %b, required 1", bus.out_valid); end
        if (bus.out_status !== 32'h100)   begin miscompares++; $display("FAIL coal_head: got %h, required 100", bus.out_status); end
        tick();
        @(negedge clk);
        vectors++;
        if (bus.out_status !== 32'h100)   begin miscompares++; $display("FAIL coal_hold: got %h, required 100", bus.out_status); end
        bus.out_ready = 1'b1;
        drain("coal", 30);
        vectors++;
        if (bus.drop_count !== 16'd2)     begin miscompares++; $display("FAIL coal_drop_after: got %0d, required 2", bus.drop_count); end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        set_hart(0, 32'hA0, 2'd1, 1'b1);
        set_hart(1, 32'hA1, 2'd2, 1'b1);
        exp_q.push_back(mk(1'b0, 32'hA0, 2'd1, 1'b0));
        exp_q.push_back(mk(1'b1, 32'hA1, 2'd2, 1'b0));
        tick();
        bus.in_valid = '0;
        tick();
        @(negedge clk);
        vectors++;
        if (bus.out_hart !== 1'b0 || bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL tie0_first: got hart=%0d valid=%b, required hart=0 valid=1", bus.out_hart, bus.out_valid); end
        tick();
        @(negedge clk);
        vectors++;
        if (bus.out_hart !== 1'b1 || bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL tie0_second: got hart=%0d valid=%b, required hart=1 valid=1", bus.out_hart, bus.out_valid); end
        drain("tie0", 20);
        set_hart(0, 32'hB0, 2'd1, 1'b1);
        exp_q.push_back(mk(1'b0, 32'hB0, 2'd1, 1'b0));
        tick();
        bus.in_valid = '0;
        drain("solo", 20);
        set_hart(0, 32'hC0, 2'd1, 1'b1);
        set_hart(1, 32'hC1, 2'd2, 1'b1);
        exp_q.push_back(mk(1'b1, 32'hC1, 2'd2, 1'b0));
        exp_q.push_back(mk(1'b0, 32'hC0, 2'd1, 1'b0));
        tick();
        bus.in_valid = '0;
        tick();
        @(negedge clk);
        vectors++;
        if (bus.out_hart !== 1'b1) begin miscompares++; $display("FAIL tie1_first: got hart=%0d, required 1", bus.out_hart); end
        tick();
        @(negedge clk);
        vectors++;
        if (bus.out_hart !== 1'b0) begin miscompares++; $display("FAIL tie1_second: got hart=%0d, required 0", bus.out_hart); end
        drain("tie1", 20);
    endtask

    task automatic test_snap();
        int base = rec_seen;
        set_hart(0, 32'hC0, 2'd1, 1'b1);
        set_hart(1, 32'hC1, 2'd2, 1'b1);
        bus.snap_req = 1'b1;
        tick();
        bus.snap_req = 1'b0;
        exp_q.push_back(mk(1'b1, 32'hC1, 2'd2, 1'b0));
        exp_q.push_back(mk(1'b0, 32'hC0, 2'd1, 1'b0));
        repeat (6) tick();
        bus.in_valid = '0;
        drain("snap", 20);
        vectors++;
        if (rec_seen != base + 2) begin miscompares++; $display("FAIL snap_count: got %0d records, required 2", rec_seen - base); end
        // Snap request coincident with a capture must survive it.
        base = rec_seen;
        set_hart(0, 32'hD0, 2'd0, 1'b1);
        bus.snap_req = 1'b1;
        exp_q.push_back(mk(1'b0, 32'hD0, 2'd0, 1'b0));
        exp_q.push_back(mk(1'b0, 32'hD0, 2'd0, 1'b0));
        tick();
        bus.snap_req = 1'b0;
        repeat (5) tick();
        bus.in_valid = '0;
        drain("snap_coinc", 20);
        vectors++;
        if (rec_seen != base + 2) begin miscompares++; $display("FAIL snap_coinc_count: got %0d records, required 2", rec_seen - base); end
    endtask

    task automatic test_reset_mid();
        int base;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_hart(0, 32'hE00 + i, 2'd3, 1'b1);
            set_hart(1, 32'hF00 + i, 2'd1, 1'b1);
            tick();
        end
        bus.in_valid = '0;
        @(negedge clk);
        vectors += 2;
        if (bus.out_valid !== 1'b1)   begin miscompares++; $display("FAIL mid_prefill: got out_valid=%b, required 1", bus.out_valid); end
        if (bus.drop_count == 16'd0)  begin miscompares++; $display("FAIL mid_drops: got %0d, required nonzero", bus.drop_count); end
        rst = 1'b1;
        tick();
        @(negedge clk);
        vectors += 3;
        if (bus.out_valid !== 1'b0)   begin miscompares++; $display("FAIL mid_reset_valid: got %b, required 0", bus.out_valid); end
        if (bus.drop_count !== 16'd0) begin miscompares++; $display("FAIL mid_reset_drop: got %0d, required 0", bus.drop_count); end
        if (bus.out_status !== 32'h0) begin miscompares++; $display("FAIL mid_reset_status: got %h, required 0", bus.out_status); end
        exp_q.delete();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        base = rec_seen;
        repeat (6) tick();
        @(negedge clk);
        vectors++;
        if (rec_seen != base || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_residue: got %0d records valid=%b, required 0 records valid=0", rec_seen - base, bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_first_record();
        test_no_change();
        test_coalesce();
        test_round_robin();
        test_snap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
